// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with registered reads and a swept clear
module reg_file_mp #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int READ_PORTS = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write_ctrl,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] r_addr,
  input  logic                             clear,
  output logic [READ_PORTS*DATA_WIDTH-1:0] r_out,
  output logic                             busy
);
  localparam int CAP = 1 << ADDR_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [CAP];
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_nx;
  logic idle_wr, blank;
  assign busy = state == CLEAR;
  assign blank = reset || state == CLEAR || clear;
  assign idle_wr = !blank && write_ctrl && !(ZERO_REG != 0 && write_addr == '0);
  // Controller next state: reset restarts the sweep, the last swept entry returns to idle
  always_comb begin
    state_nx = (reset || (state == IDLE && clear) || (state == CLEAR && !(&cnt))) ? CLEAR : IDLE;
    cnt_nx = (reset || state == IDLE) ? '0 : cnt + 1'b1;
  end
  // Controller and read data registers
  always_ff @(posedge clock) begin
    state <= state_nx;
    cnt <= cnt_nx;
    r_out <= rd_nx;
  end
  // Storage has no reset of its own; the sweep zeroes it one entry per cycle
  always_ff @(posedge clock) begin
    if (!reset && state == CLEAR) mem[cnt] <= '0;
    else if (idle_wr) mem[write_addr] <= write_data;
  end
  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_nx[k*DATA_WIDTH +: DATA_WIDTH] =
      (blank || (ZERO_REG != 0 && ra == '0)) ? '0 :
      (BYPASS != 0 && idle_wr && write_addr == ra) ? write_data : mem[ra];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of two reg_file_mp configurations
module tb_reg_file_mp;
  logic clock = 0, reset, write_ctrl, clear;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [5:0] r_addr;
  logic [15:0] out_a, out_b;
  logic busy_a, busy_b;
  int n_chk = 0, n_fail = 0;
  logic [7:0] ma [8];
  logic [7:0] mb [8];
  int left = 0;
  logic [15:0] ea, eb;
  logic ebusy;

  always #5 clock = ~clock;

  reg_file_mp dut_a (.clock(clock), .reset(reset), .write_ctrl(write_ctrl), .write_addr(write_addr),
    .write_data(write_data), .r_addr(r_addr), .clear(clear), .r_out(out_a), .busy(busy_a));
  reg_file_mp #(.BYPASS(0), .ZERO_REG(1)) dut_b (.clock(clock), .reset(reset), .write_ctrl(write_ctrl),
    .write_addr(write_addr), .write_data(write_data), .r_addr(r_addr), .clear(clear), .r_out(out_b),
    .busy(busy_b));

  task automatic drive(input bit r, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a0, input logic [2:0] a1, input bit clr);
    reset = r; write_ctrl = we; write_addr = wa; write_data = wd; r_addr = {a1, a0}; clear = clr;
  endtask

  // One clock: the model predicts both configurations from the current inputs, then the edge occurs
  task automatic cycle();
    logic [15:0] na, nb;
    logic [2:0] a;
    bit blank, wr;
    blank = reset || left > 0 || clear;
    wr = !blank && write_ctrl;
    for (int k = 0; k < 2; k++) begin
      a = r_addr[k*3 +: 3];
      na[k*8 +: 8] = blank ? 8'h00 : (wr && write_addr == a) ? write_data : ma[a];
      nb[k*8 +: 8] = (blank || a == 0) ? 8'h00 : mb[a];
    end
    if (reset) left = 8;
    else if (left > 0) begin
      ma[8-left] = 8'h00; mb[8-left] = 8'h00; left--;
    end else if (clear) left = 8;
    else if (wr) begin
      ma[write_addr] = write_data;
      if (write_addr != 0) mb[write_addr] = write_data;
    end
    @(posedge clock); #1;
    ea = na; eb = nb; ebusy = left > 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 3'(i), 3'(7-i), 0); cycle();
      n_chk++;
      if (out_a !== 16'h0 || out_b !== 16'h0) begin
        n_fail++; $display("FAIL %s addr %0d: got a=%h b=%h expected 0000", tag, i, out_a, out_b);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    drive(1, 1, 3, 8'h33, 3, 3, 1); cycle(); cycle();
    n_chk++;
    if (busy_a !== 1 || busy_b !== 1 || out_a !== 16'h0 || out_b !== 16'h0) begin
      n_fail++; $display("FAIL reset_state: busy=%b/%b out=%h/%h expected busy 1 out 0", busy_a, busy_b, out_a, out_b);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    do begin cycle(); n++; end while (busy_a && n < 20);
    n_chk++;
    if (n != 8 || busy_b !== 0) begin
      n_fail++; $display("FAIL reset_sweep_len: got %0d cycles (busy_b=%b) expected 8", n, busy_b);
    end
    read_all_zero("reset_contents");
  endtask

  task automatic test_write_read();
    drive(0, 1, 3, 8'hA5, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 3, 3, 0); cycle();
    n_chk++;
    if (out_a !== 16'hA5A5 || out_b !== 16'hA5A5) begin
      n_fail++; $display("FAIL write_read: got a=%h b=%h expected a5a5", out_a, out_b);
    end
  endtask

  task automatic test_bypass();
    drive(0, 1, 4, 8'h11, 0, 0, 0); cycle();
    drive(0, 1, 4, 8'h5A, 4, 4, 0); cycle();
    n_chk++;
    if (out_a !== 16'h5A5A) begin
      n_fail++; $display("FAIL bypass_write_first: got %h expected 5a5a", out_a);
    end
    n_chk++;
    if (out_b !== 16'h1111) begin
      n_fail++; $display("FAIL bypass_read_first: got %h expected 1111", out_b);
    end
    drive(0, 0, 0, 0, 4, 4, 0); cycle();
    n_chk++;
    if (out_b !== 16'h5A5A) begin
      n_fail++; $display("FAIL bypass_next_read: got %h expected 5a5a", out_b);
    end
  endtask

  task automatic test_zero_reg();
    drive(0, 1, 0, 8'hFF, 0, 0, 0); cycle();
    drive(0, 1, 1, 8'hFF, 0, 1, 0); cycle();
    n_chk++;
    if (out_b[7:0] !== 8'h00 || out_a[7:0] !== 8'hFF) begin
      n_fail++; $display("FAIL zero_reg_read0: got a=%h b=%h expected a lo ff, b lo 00", out_a, out_b);
    end
    drive(0, 0, 0, 0, 0, 1, 0); cycle();
    n_chk++;
    if (out_b !== 16'hFF00 || out_a !== 16'hFFFF) begin
      n_fail++; $display("FAIL zero_reg_read1: got a=%h b=%h expected a ffff b ff00", out_a, out_b);
    end
    drive(0, 1, 0, 8'h42, 0, 0, 0); cycle();
    n_chk++;
    if (out_b !== 16'h0000 || out_a !== 16'h4242) begin
      n_fail++; $display("FAIL zero_reg_bypass: got a=%h b=%h expected a 4242 b 0000", out_a, out_b);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 8; i++) begin drive(0, 1, 3'(i), 8'(8'h10 + i), 0, 0, 0); cycle(); end
    drive(0, 0, 0, 0, 2, 5, 0); cycle();
    n_chk++;
    if (out_a !== 16'h1512 || out_b !== 16'h1512) begin
      n_fail++; $display("FAIL clear_prefill: got a=%h b=%h expected 1512", out_a, out_b);
    end
    drive(0, 1, 2, 8'h99, 2, 2, 1); cycle();
    n_chk++;
    if (busy_a !== 1 || busy_b !== 1) begin
      n_fail++; $display("FAIL clear_start: busy=%b/%b expected 1", busy_a, busy_b);
    end
    n = 0;
    while (busy_a && n < 20) begin
      drive(0, 1, 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
      cycle(); n++;
      n_chk++;
      if (out_a !== 16'h0 || out_b !== 16'h0) begin
        n_fail++; $display("FAIL clear_rout_zero: cycle %0d got a=%h b=%h expected 0000", n, out_a, out_b);
      end
    end
    n_chk++;
    if (n != 8 || busy_b !== 0) begin
      n_fail++; $display("FAIL clear_sweep_len: got %0d cycles (busy_b=%b) expected 8", n, busy_b);
    end
    read_all_zero("clear_contents");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bit dropped;
    for (int i = 0; i < 8; i++) begin drive(0, 1, 3'(i), 8'(8'h70 + i), 0, 0, 0); cycle(); end
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    dropped = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin cycle(); if (busy_a !== 1 || busy_b !== 1) dropped = 1; end
    n_chk++;
    if (dropped) begin
      n_fail++; $display("FAIL midreset_busy: busy dropped during reset, expected 1");
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    do begin cycle(); n++; end while (busy_a && n < 20);
    n_chk++;
    if (n != 8) begin
      n_fail++; $display("FAIL midreset_sweep_len: got %0d cycles expected 8", n);
    end
    read_all_zero("midreset_contents");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(59) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
            3'($urandom), 3'($urandom), $urandom_range(24) == 0);
      cycle();
      n_chk++;
      if (out_a !== ea || out_b !== eb || busy_a !== ebusy || busy_b !== ebusy) begin
        n_fail++;
        $display("FAIL random[%0d]: got a=%h b=%h busy=%b/%b expected a=%h b=%h busy=%b",
                 i, out_a, out_b, busy_a, busy_b, ea, eb, ebusy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end
    drive(1, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, address width; depth CAP = 2^ADDR_WIDTH entries, all addressable.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, entry width in bits.
REQ-003 SHALL have parameter READ_PORTS, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter BYPASS, default 1: 1 = write-first same-cycle forwarding, 0 = read-first (old data).
REQ-005 SHALL have parameter ZERO_REG, default 0: 1 = entry 0 hardwired to zero.
REQ-006 SHALL have port clock  input  1  the single clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port write_ctrl  input  1  write enable.
REQ-009 SHALL have port write_addr  input  ADDR_WIDTH  write address.
REQ-010 SHALL have port write_data  input  DATA_WIDTH  write data.
REQ-011 SHALL have port r_addr  input  READ_PORTS*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port clear  input  1  single-cycle request to zero all entries.
REQ-013 SHALL have port r_out  output  READ_PORTS*DATA_WIDTH  packed registered read data; port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port busy  output  1  registered; high while clear sweep in progress.

Function
REQ-015 SHALL implement a two-state controller: IDLE and CLEAR, plus a sweep counter of ADDR_WIDTH bits.
REQ-016 In IDLE, read latency SHALL be one cycle: r_out[k] after posedge N = entry r_addr[k] sampled at N.
REQ-017 In IDLE with write_ctrl=1, entry write_addr SHALL take write_data at the posedge.
REQ-018 Same-cycle write and read of the same address: BYPASS=1 -> r_out[k] = write_data; BYPASS=0 -> r_out[k] = prior entry contents.
REQ-019 Multiple read ports addressing the same entry SHALL all return identical data.
REQ-020 ZERO_REG=1: writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0, no bypass to address 0.
REQ-021 In IDLE, clear=1 SHALL move to CLEAR with counter=0 and busy=1 at that posedge; a write in the same cycle SHALL be dropped.
REQ-022 In CLEAR, each posedge SHALL write 0 to entry counter and increment counter.
REQ-023 The posedge that zeroes entry CAP-1 SHALL return to IDLE and deassert busy; the sweep SHALL take exactly CAP cycles.
REQ-024 In CLEAR, write_ctrl and clear SHALL be ignored (no restart) and r_out SHALL be driven 0 on all ports.
REQ-025 Counter wrap from CAP-1 SHALL not occur; the transition to IDLE takes precedence.

Reset
REQ-026 reset=1 at a posedge SHALL force state=CLEAR, counter=0, busy=1, r_out=0, overriding every other input.
REQ-027 While reset stays high, counter SHALL hold at 0; the sweep SHALL begin at the first posedge with reset=0 and complete CAP posedges later.
REQ-028 reset asserted mid-sweep SHALL restart the sweep from entry 0; full CAP cycles required again.
REQ-029 Storage SHALL have no reset other than the sweep; no entry is readable as nonzero before busy falls.

Verification (ADDR_WIDTH=3, DATA_WIDTH=8, READ_PORTS=2 unless noted)
REQ-030 Reset 2 cycles, release -> busy high exactly 8 cycles after release, then read addresses 0..7 on both ports -> all 0x00.
REQ-031 Write 0xA5 to addr 3; next cycle r_addr port0=3, port1=3 -> both r_out = 0xA5 one cycle later.
REQ-032 Entry 4 = 0x11; same cycle write 0x5A to addr 4 and read addr 4 -> BYPASS=1: 0x5A; BYPASS=0: 0x11, then 0x5A on next read.
REQ-033 ZERO_REG=1: write 0xFF to addr 0, read addr 0 -> 0x00; write 0xFF to addr 1 -> reads 0xFF.
REQ-034 Fill addrs 0..7 with 0x10..0x17, pulse clear with simultaneous write 0x99 to addr 2 -> busy 8 cycles, writes/clear during busy ignored, r_out=0 during busy, all entries 0x00 afterwards.
REQ-035 Start clear, assert reset on sweep cycle 3 -> busy stays high, sweep restarts; busy falls 8 cycles after reset release; all entries 0x00.
